// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle ARM controller and its datapath.
// The slave modport is the controller side; master drives the instruction bits and ALU flags.
interface multicycle_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUControl;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [3:0]  State;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
    input  ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, State
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
    output ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM with NZCV flag register and condition evaluation.
// Define MC_CMP_EN to decode cmd 1010 as CMP (sub, forced flag write, no register write).
module multicycle_controller #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.slave        bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^bus.Instr[7:4];

  logic [1:0] dec_alu;
  logic       dec_flag_all, dec_flag_nz, no_write;

  always_comb begin
    dec_alu      = 2'b00;
    dec_flag_all = 1'b0;
    dec_flag_nz  = 1'b0;
    no_write     = 1'b0;
    case (cmd)
      4'b0100: begin dec_alu = 2'b00; dec_flag_all = funct[0]; end
      4'b0010: begin dec_alu = 2'b01; dec_flag_all = funct[0]; end
      4'b0000: begin dec_alu = 2'b10; dec_flag_nz  = funct[0]; end
      4'b1100: begin dec_alu = 2'b11; dec_flag_nz  = funct[0]; end
`ifdef MC_CMP_EN
      4'b1010: begin dec_alu = 2'b01; dec_flag_all = 1'b1; no_write = (op == 2'b00); end
`else
      4'b1010: begin dec_alu = 2'b00; end
`endif
      default: begin dec_alu = 2'b00; end
    endcase
  end

  logic n_f, z_f, c_f, v_f, cond_ex;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = z_f;
      4'h1: cond_ex = ~z_f;
      4'h2: cond_ex = c_f;
      4'h3: cond_ex = ~c_f;
      4'h4: cond_ex = n_f;
      4'h5: cond_ex = ~n_f;
      4'h6: cond_ex = v_f;
      4'h7: cond_ex = ~v_f;
      4'h8: cond_ex = c_f & ~z_f;
      4'h9: cond_ex = ~c_f | z_f;
      4'hA: cond_ex = (n_f == v_f);
      4'hB: cond_ex = (n_f != v_f);
      4'hC: cond_ex = ~z_f & (n_f == v_f);
      4'hD: cond_ex = z_f | (n_f != v_f);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic       pc_uncond, ir_w, reg_w, mem_w, branch, flag_en;
  logic       adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, alu_control;

  always_comb begin
    state_d     = FETCH;
    pc_uncond   = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    branch      = 1'b0;
    flag_en     = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    case (state_q)
      FETCH: begin
        state_d    = DECODE;
        ir_w       = 1'b1;
        pc_uncond  = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d   = funct[0] ? MEMRD : MEMWR;
        alu_src_b = 2'b01;
      end
      MEMRD: begin
        state_d = MEMWB;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECR, EXECI: begin
        state_d     = ALUWB;
        alu_src_b   = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_control = dec_alu;
        flag_en     = 1'b1;
      end
      ALUWB: begin
        result_src = 2'b00;
        reg_w      = 1'b1;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // and/orr touch only N and Z; carry and overflow survive from the previous setter.
  always_comb begin
    flags_d = flags_q;
    if (flag_en && cond_ex) begin
      if (dec_flag_all)
        flags_d = bus.ALUFlags;
      else if (dec_flag_nz)
        flags_d[3:2] = bus.ALUFlags[3:2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      flags_q <= FLAGS_RST;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Enables are qualified with reset so nothing commits while it is held low.
  assign bus.PCWrite    = reset & (pc_uncond | (cond_ex & (branch | (reg_w & (rd == 4'hF)))));
  assign bus.IRWrite    = reset & ir_w;
  assign bus.MemWrite   = reset & mem_w & cond_ex;
  assign bus.RegWrite   = reset & reg_w & cond_ex & ~no_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.State      = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus random instructions
// checked against an instruction-level model of sequence, write events and NZCV.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] FLAGS_RST = 4'b0000;

  multicycle_controller_if bus();
  multicycle_controller #(.FLAGS_RST(FLAGS_RST)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] mdl_flags;

  logic [3:0] obs_state [0:7];
  logic       obs_pcw [0:7], obs_irw [0:7], obs_memw [0:7], obs_regw [0:7];
  logic       obs_adr [0:7], obs_srca [0:7];
  logic [1:0] obs_res [0:7], obs_srcb [0:7], obs_aluctl [0:7], obs_imm [0:7], obs_regsrc [0:7];

  // ---------------- reference model ----------------
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    if (cond == 4'hE) return 1'b1;
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return cond[0] ? !base : base;
  endfunction

  function automatic int latency(input logic [19:0] ins);
    case (ins[15:14])
      2'd0: return 4;
      2'd1: return ins[8] ? 5 : 4;
      2'd2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] exp_state(input logic [19:0] ins, input int k);
    if (k < 2) return 4'(k);
    case (ins[15:14])
      2'd0: return (k == 2) ? (ins[13] ? 4'd7 : 4'd6) : 4'd8;
      2'd1: return ins[8] ? 4'(k) : ((k == 2) ? 4'd2 : 4'd5);
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic is_cmp(input logic [19:0] ins);
`ifdef MC_CMP_EN
    return (ins[15:14] == 2'd0) && (ins[12:9] == 4'b1010);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] exp_alu(input logic [19:0] ins);
    if (is_cmp(ins)) return 2'b01;
    case (ins[12:9])
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic mdl_update(input logic [19:0] ins, input logic [3:0] af);
    logic [3:0] cmd;
    cmd = ins[12:9];
    if (ins[15:14] == 2'd0 && cond_ok(ins[19:16], mdl_flags)) begin
      if (is_cmp(ins) || ((cmd == 4'b0100 || cmd == 4'b0010) && ins[8]))
        mdl_flags = af;
      else if ((cmd == 4'b0000 || cmd == 4'b1100) && ins[8])
        mdl_flags[3:2] = af[3:2];
    end
  endtask

  // Drives one instruction for its full latency and records outputs mid-cycle.
  task automatic exec_instr(input logic [19:0] ins, input logic [3:0] af);
    int n;
    n = latency(ins);
    bus.Instr = ins;
    bus.ALUFlags = af;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs_state[k] = bus.State;   obs_pcw[k] = bus.PCWrite;   obs_irw[k] = bus.IRWrite;
      obs_memw[k] = bus.MemWrite; obs_regw[k] = bus.RegWrite; obs_adr[k] = bus.AdrSrc;
      obs_srca[k] = bus.ALUSrcA;  obs_srcb[k] = bus.ALUSrcB;  obs_res[k] = bus.ResultSrc;
      obs_aluctl[k] = bus.ALUControl; obs_imm[k] = bus.ImmSrc; obs_regsrc[k] = bus.RegSrc;
      @(posedge clk);
      #1;
    end
    $display("instr %05h aluflags %b cycles %0d states %0d,%0d,%0d,%0d,%0d", ins, af, n,
             obs_state[0], obs_state[1], obs_state[2], obs_state[3], obs_state[4]);
    mdl_update(ins, af);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    bus.Instr = 20'h0;
    bus.ALUFlags = 4'h0;
    #2;
    n_checks++; if (bus.State !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.State); end
    n_checks++; if ({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_enables: got %b expected 0000", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}); end
    @(posedge clk); #1;
    reset = 1'b1;
    mdl_flags = FLAGS_RST;
    exec_instr(20'hE2911, 4'b0100);
    bus.Instr = 20'hE5901;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (bus.State !== 4'd3) begin n_fail++; $display("FAIL pre_reset_memrd: got %0d expected 3", bus.State); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.State !== 4'd0) begin n_fail++; $display("FAIL async_reset_state: got %0d expected 0", bus.State); end
    n_checks++; if ({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite} !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_enables: got %b expected 0000", {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}); end
    n_checks++; if ({bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc} !== 6'b0_1_10_10) begin
      n_fail++; $display("FAIL reset_fetch_selects: got %b expected 011010", {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc}); end
    mdl_flags = FLAGS_RST;
    @(posedge clk); #1;
    n_checks++; if (bus.State !== 4'd0) begin n_fail++; $display("FAIL reset_hold_state: got %0d expected 0", bus.State); end
    reset = 1'b1;
    exec_instr(20'h0A000, 4'b0000);
    n_checks++; if ({obs_irw[0], obs_pcw[0]} !== 2'b11) begin
      n_fail++; $display("FAIL release_fetch_irw_pcw: got %b expected 11", {obs_irw[0], obs_pcw[0]}); end
    n_checks++; if (obs_pcw[2] !== 1'b0) begin n_fail++; $display("FAIL flags_cleared_beq: got %b expected 0", obs_pcw[2]); end
  endtask

  task automatic test_dp;
    exec_instr(20'hE0821, 4'($urandom));
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (obs_state[k] !== exp_state(20'hE0821, k)) begin
        n_fail++; $display("FAIL add_state[%0d]: got %0d expected %0d", k, obs_state[k], exp_state(20'hE0821, k)); end
      n_checks++; if (obs_regw[k] !== (k == 3)) begin
        n_fail++; $display("FAIL add_regwrite[%0d]: got %b expected %b", k, obs_regw[k], k == 3); end
    end
    n_checks++; if ({obs_aluctl[2], obs_srcb[2]} !== 4'b0000) begin
      n_fail++; $display("FAIL add_execr_sel: got %b expected 0000", {obs_aluctl[2], obs_srcb[2]}); end
  endtask

  task automatic test_ldr_str;
    exec_instr(20'hE5901, 4'h0);
    n_checks++; if ({obs_state[2], obs_state[3], obs_state[4]} !== {4'd2, 4'd3, 4'd4}) begin
      n_fail++; $display("FAIL ldr_states: got %0d,%0d,%0d expected 2,3,4", obs_state[2], obs_state[3], obs_state[4]); end
    n_checks++; if (obs_adr[3] !== 1'b1) begin n_fail++; $display("FAIL ldr_adrsrc: got %b expected 1", obs_adr[3]); end
    n_checks++; if ({obs_res[4], obs_regw[4]} !== 3'b011) begin
      n_fail++; $display("FAIL ldr_memwb: got %b expected 011", {obs_res[4], obs_regw[4]}); end
    exec_instr(20'hE5801, 4'h0);
    n_checks++; if (obs_state[3] !== 4'd5) begin n_fail++; $display("FAIL str_state: got %0d expected 5", obs_state[3]); end
    n_checks++; if ({obs_memw[2], obs_memw[3]} !== 2'b01) begin
      n_fail++; $display("FAIL str_memwrite: got %b expected 01", {obs_memw[2], obs_memw[3]}); end
  endtask

  task automatic test_flags_branch;
    exec_instr(20'hE2911, 4'b0100);
    exec_instr(20'h0A000, 4'h0);
    n_checks++; if ({obs_state[2], obs_pcw[2]} !== {4'd9, 1'b1}) begin
      n_fail++; $display("FAIL beq_taken: got %0d/%b expected 9/1", obs_state[2], obs_pcw[2]); end
    exec_instr(20'hE2911, 4'b0000);
    exec_instr(20'h0A000, 4'h0);
    n_checks++; if ({obs_state[2], obs_pcw[2]} !== {4'd9, 1'b0}) begin
      n_fail++; $display("FAIL beq_not_taken: got %0d/%b expected 9/0", obs_state[2], obs_pcw[2]); end
  endtask

  task automatic test_pc_write;
    exec_instr(20'hE080F, 4'h0);
    n_checks++; if ({obs_pcw[3], obs_regw[3]} !== 2'b11) begin
      n_fail++; $display("FAIL add_pc_writes: got %b expected 11", {obs_pcw[3], obs_regw[3]}); end
    exec_instr(20'hF0821, 4'h0);
    n_checks++; if ({obs_pcw[3], obs_regw[3]} !== 2'b00) begin
      n_fail++; $display("FAIL cond_never_writes: got %b expected 00", {obs_pcw[3], obs_regw[3]}); end
  endtask

  task automatic test_cmp;
    logic exp_rw;
    logic [3:0] exp_f;
    logic [19:0] probe [0:3];
    int bit_of [0:3];
`ifdef MC_CMP_EN
    exp_rw = 1'b0; exp_f = 4'b0110;
`else
    exp_rw = 1'b1; exp_f = 4'b0000;
`endif
    probe[0] = 20'h00821; probe[1] = 20'h20821; probe[2] = 20'h40821; probe[3] = 20'h60821;
    bit_of[0] = 2; bit_of[1] = 1; bit_of[2] = 3; bit_of[3] = 0;
    exec_instr(20'hE2911, 4'b0000);
    exec_instr(20'hE1520, 4'b0110);
    n_checks++; if (obs_regw[3] !== exp_rw) begin
      n_fail++; $display("FAIL cmp_regwrite: got %b expected %b", obs_regw[3], exp_rw); end
    for (int p = 0; p < 4; p++) begin
      exec_instr(probe[p], 4'h0);
      n_checks++; if (obs_regw[3] !== exp_f[bit_of[p]]) begin
        n_fail++; $display("FAIL cmp_flag_probe[%0d]: got %b expected %b", p, obs_regw[3], exp_f[bit_of[p]]); end
    end
  endtask

  task automatic test_random;
    logic [19:0] ins;
    logic [3:0]  af;
    logic [1:0]  op;
    logic        ce, regw_inst;
    logic        e_pcw, e_rw, e_mw;
    int          last;
    for (int i = 0; i < 150; i++) begin
      ins = 20'($urandom);
      af  = 4'($urandom);
      op  = ins[15:14];
      // Flag-setting instructions are kept AL so CondEx is the same before and after the update.
      if (op == 2'd0 && ins[19:16] < 4'hE && (ins[8] || is_cmp(ins))) ins[19:16] = 4'hE;
      ce = cond_ok(ins[19:16], mdl_flags);
      regw_inst = (op == 2'd0) || (op == 2'd1 && ins[8]);
      last = latency(ins) - 1;
      exec_instr(ins, af);
      for (int k = 0; k <= last; k++) begin
        e_pcw = (k == 0) || (k == last && ce && (op == 2'd2 || (regw_inst && ins[3:0] == 4'hF)));
        e_rw  = (k == last) && regw_inst && ce && !is_cmp(ins);
        e_mw  = (k == last) && op == 2'd1 && !ins[8] && ce;
        n_checks++; if (obs_state[k] !== exp_state(ins, k)) begin
          n_fail++; $display("FAIL rnd_state %05h[%0d]: got %0d expected %0d", ins, k, obs_state[k], exp_state(ins, k)); end
        n_checks++; if ({obs_pcw[k], obs_irw[k], obs_regw[k], obs_memw[k]} !== {e_pcw, k == 0, e_rw, e_mw}) begin
          n_fail++; $display("FAIL rnd_enables %05h[%0d]: got %b expected %b", ins, k,
                             {obs_pcw[k], obs_irw[k], obs_regw[k], obs_memw[k]}, {e_pcw, k == 0, e_rw, e_mw}); end
        n_checks++; if ({obs_imm[k], obs_regsrc[k]} !== {op, op == 2'd1, op == 2'd2}) begin
          n_fail++; $display("FAIL rnd_imm_regsrc %05h[%0d]: got %b expected %b", ins, k,
                             {obs_imm[k], obs_regsrc[k]}, {op, op == 2'd1, op == 2'd2}); end
      end
      n_checks++; if ({obs_adr[0], obs_srca[0], obs_srcb[0], obs_res[0]} !== 6'b0_1_10_10) begin
        n_fail++; $display("FAIL rnd_fetch_sel %05h: got %b expected 011010", ins, {obs_adr[0], obs_srca[0], obs_srcb[0], obs_res[0]}); end
      if (op == 2'd0) begin
        n_checks++; if ({obs_aluctl[2], obs_srcb[2]} !== {exp_alu(ins), 1'b0, ins[13]}) begin
          n_fail++; $display("FAIL rnd_exec_sel %05h: got %b expected %b", ins, {obs_aluctl[2], obs_srcb[2]}, {exp_alu(ins), 1'b0, ins[13]}); end
      end else if (op == 2'd1) begin
        n_checks++; if ({obs_srca[2], obs_srcb[2], obs_aluctl[2], obs_adr[3]} !== 6'b0_01_00_1) begin
          n_fail++; $display("FAIL rnd_mem_sel %05h: got %b expected 001001", ins, {obs_srca[2], obs_srcb[2], obs_aluctl[2], obs_adr[3]}); end
      end else if (op == 2'd2) begin
        n_checks++; if ({obs_srca[2], obs_srcb[2], obs_res[2]} !== 5'b0_01_10) begin
          n_fail++; $display("FAIL rnd_branch_sel %05h: got %b expected 00110", ins, {obs_srca[2], obs_srcb[2], obs_res[2]}); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_flags = FLAGS_RST;
    test_reset();
    test_dp();
    test_ldr_str();
    test_flags_branch();
    test_pc_write();
    test_cmp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that time-multiplexes the ARM datapath (single ALU, unified memory) across multiple cycles per instruction: FETCH, DECODE, then EXECUTE/MEMORY/WRITEBACK steps.
- Decodes data-processing (ADD/SUB/AND/ORR), LDR/STR with immediate offset, and B.
- Holds the NZCV flag register and evaluates the condition field.
- Sits beside the multicycle datapath; drives every mux select and write enable.

Parameters:
- FLAGS_RST, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  20  IR bits [31:12]: cond[19:16], op[15:14], funct[13:8], Rd[3:0].
- ALUFlags  in  4  NZCV from ALU, current cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register enable.
- ResultSrc  out  2  result select: 00 = ALUOut reg, 01 = Data reg, 10 = ALU direct.
- ALUControl  out  2  ALU operation: 00 = add, 01 = sub, 10 = and, 11 = orr.
- ALUSrcA  out  1  SrcA select: 0 = RD1 reg, 1 = PC.
- ALUSrcB  out  2  SrcB select: 00 = shifted RD2, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  extender mode; equals op.
- RegSrc  out  2  RegSrc[0] = (op==10); RegSrc[1] = (op==01).
- RegWrite  out  1  register file write enable.
- State  out  4  current FSM state, debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10–15 go to FETCH next cycle with all enables 0.
- Reset low, asynchronous:
  - State = FETCH, flags = FLAGS_RST.
  - PCWrite, IRWrite, MemWrite and RegWrite forced to 0 while reset is low.
  - Other outputs take their FETCH values.
- Transitions:
  - FETCH → DECODE.
  - DECODE: op=01 → MEMADR; op=00 with funct[5]=0 → EXECR; op=00 with funct[5]=1 → EXECI; op=10 → BRANCH; op=11 → FETCH.
  - MEMADR: funct[0]=1 → MEMRD, else MEMWR.
  - MEMRD → MEMWB → FETCH. MEMWR → FETCH.
  - EXECR/EXECI → ALUWB → FETCH.
  - BRANCH → FETCH.
- Latency in cycles: DP 4, LDR 5, STR 4, B 3, op=11 2.
- Per-state outputs (unlisted enables are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1 unconditionally.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, add.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALU op from cmd. EXECI: ALUSrcB=01, ALU op from cmd.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, add, ResultSrc=10, Branch=1.
- cmd = funct[4:1]: 0100 add, 0010 sub, 0000 and, 1100 orr. Any other cmd uses add with no flag write.
- Condition check CondEx, evaluated against the flag register (not ALUFlags):
  - Codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE; AL(1110) = 1.
  - 1111 = 0.
- Gating:
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
  - PCWrite = FETCH | (CondEx & (Branch | (RegW & Rd==4'hF))).
- Flag update:
  - Only at the rising edge ending EXECR/EXECI, and only when funct[0]=1 (S bit) and CondEx.
  - add/sub write all of NZCV; and/orr write NZ only and preserve CV.
- A failed condition still walks the full state sequence; only the writes are suppressed.

Optional Feature:
- Macro MC_CMP_EN.
- Defined: cmd 1010 (CMP) uses sub, forces flag write of all of NZCV regardless of the S bit (subject to CondEx), and sets NoWrite=1, so RegWrite stays 0 in ALUWB.
- Undefined: cmd 1010 follows the "other cmd" rule (add, no flag write, NoWrite=0).

Test Plan:
- Reset low mid-MEMRD (LDR in flight) → State=0 immediately, all enables 0; flags=FLAGS_RST; after release, FETCH asserts IRWrite=1 and PCWrite=1.
- Instr=0xE0821 (ADD R1,R2,R3) → states 0,1,6,8,0; ALUControl=00 and ALUSrcB=00 in EXECR; RegWrite=1 only in ALUWB.
- Instr=0xE5901 (LDR R1,[R0,#4]) → states 0,1,2,3,4; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. Instr=0xE5801 (STR) → states 0,1,2,5; MemWrite=1 in MEMWR.
- Instr=0xE2911 (ADDS imm) with ALUFlags=0100 → Z set; next Instr=0x0A000 (BEQ) → PCWrite=1 in BRANCH. Same BEQ with Z=0 → PCWrite=0 in BRANCH.
- Instr=0xE080F (ADD PC,R0,R0) → PCWrite=1 and RegWrite=1 in ALUWB. Instr=0xF0821 (cond 1111) → RegWrite=0 in ALUWB.
- MC_CMP_EN defined, Instr=0xE1520 (CMP R2,R3) with ALUFlags=0110 → flags=0110, RegWrite=0 in ALUWB. Undefined → flags unchanged, RegWrite=1 in ALUWB.
